// File: rtl/dhms_pkg.sv
// Shared constants, field widths and state type for the d/h/m/s countdown timer.
package dhms_pkg;

   localparam int SEC_MAX = 59;
   localparam int MIN_MAX = 59;
   localparam int HRS_MAX = 23;

   localparam int SEC_W = 6;
   localparam int MIN_W = 6;
   localparam int HRS_W = 5;
   localparam int DAY_W = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSE   = 2'd2,
      EXPIRED = 2'd3
   } dhms_cd_state_t;

endpackage

// File: rtl/dhms_down_digit.sv
// Modulo-(MAX+1) down counter digit with synchronous load and borrow output.
module dhms_down_digit #(
   parameter int MAX = 59,
   parameter int W   = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value,
   output logic         borrow_out
);

   localparam logic [W-1:0] TOP = W'(MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (en) begin
         value <= (value == '0) ? TOP : value - W'(1);
      end
   end

   assign borrow_out = en && (value == '0);

endmodule

// File: rtl/dhms_countdown.sv
// Days/hours/minutes/seconds countdown timer with expiry pulse.
// Define DHMS_CD_AUTO_RELOAD_EN for periodic reload from the last loaded value.
module dhms_countdown
   import dhms_pkg::*;
#(
   parameter int DAY_MAX = 30
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             load,
   input  logic [DAY_W-1:0] load_day,
   input  logic [HRS_W-1:0] load_hrs,
   input  logic [MIN_W-1:0] load_min,
   input  logic [SEC_W-1:0] load_sec,
   input  logic             start,
   input  logic             stop,
   output logic [DAY_W-1:0] day,
   output logic [HRS_W-1:0] hrs,
   output logic [MIN_W-1:0] min,
   output logic [SEC_W-1:0] sec,
   output logic             running,
   output logic             done,
   output logic             load_err
);

   dhms_cd_state_t state, state_nxt;

   logic load_ok, ld_ok;
   logic is_zero, is_one;
   logic dec, reload;
   logic done_nxt, err_nxt;
   logic sec_bo, min_bo, hrs_bo;
   logic digit_load;
   logic [SEC_W-1:0] sec_src;
   logic [MIN_W-1:0] min_src;
   logic [HRS_W-1:0] hrs_src;
   logic [DAY_W-1:0] day_src;
   logic shadow_nz;

   assign load_ok = (int'(load_sec) <= SEC_MAX) &&
                    (int'(load_min) <= MIN_MAX) &&
                    (int'(load_hrs) <= HRS_MAX) &&
                    (int'(load_day) <= DAY_MAX);
   assign ld_ok   = load && load_ok;

   assign is_zero = (day == '0) && (hrs == '0) &&
                    (min == '0) && (sec == '0);
   assign is_one  = (day == '0) && (hrs == '0) &&
                    (min == '0) && (sec == SEC_W'(1));

`ifdef DHMS_CD_AUTO_RELOAD_EN
   logic [DAY_W-1:0] sh_day;
   logic [HRS_W-1:0] sh_hrs;
   logic [MIN_W-1:0] sh_min;
   logic [SEC_W-1:0] sh_sec;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_day <= '0;
         sh_hrs <= '0;
         sh_min <= '0;
         sh_sec <= '0;
      end else if (ld_ok) begin
         sh_day <= load_day;
         sh_hrs <= load_hrs;
         sh_min <= load_min;
         sh_sec <= load_sec;
      end
   end

   assign shadow_nz = (sh_day != '0) || (sh_hrs != '0) ||
                      (sh_min != '0) || (sh_sec != '0);
   assign sec_src   = ld_ok ? load_sec : sh_sec;
   assign min_src   = ld_ok ? load_min : sh_min;
   assign hrs_src   = ld_ok ? load_hrs : sh_hrs;
   assign day_src   = ld_ok ? load_day : sh_day;
`else
   assign shadow_nz = 1'b0;
   assign sec_src   = load_sec;
   assign min_src   = load_min;
   assign hrs_src   = load_hrs;
   assign day_src   = load_day;
`endif

   // One request wins per cycle: load, stop, start, then tick.
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      dec       = 1'b0;
      reload    = 1'b0;
      if (load) begin
         if (load_ok) state_nxt = IDLE;
         else         err_nxt   = 1'b1;
      end else if (stop && state == RUN) begin
         state_nxt = PAUSE;
      end else if (start && (state == IDLE || state == PAUSE)) begin
         if (is_zero) begin
            state_nxt = EXPIRED;
            done_nxt  = 1'b1;
         end else begin
            state_nxt = RUN;
         end
      end else if (tick && state == RUN) begin
         dec = 1'b1;
         if (is_one) begin
            done_nxt = 1'b1;
            if (shadow_nz) reload    = 1'b1;
            else           state_nxt = EXPIRED;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         running  <= 1'b0;
         done     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         running  <= (state_nxt == RUN);
         done     <= done_nxt;
         load_err <= err_nxt;
      end
   end

   assign digit_load = ld_ok || reload;

   dhms_down_digit #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
      .clk(clk), .rst(rst), .en(dec), .load(digit_load),
      .load_val(sec_src), .value(sec), .borrow_out(sec_bo)
   );

   dhms_down_digit #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
      .clk(clk), .rst(rst), .en(sec_bo), .load(digit_load),
      .load_val(min_src), .value(min), .borrow_out(min_bo)
   );

   dhms_down_digit #(.MAX(HRS_MAX), .W(HRS_W)) u_hrs (
      .clk(clk), .rst(rst), .en(min_bo), .load(digit_load),
      .load_val(hrs_src), .value(hrs), .borrow_out(hrs_bo)
   );

   // Zero check upstream guarantees day is non-zero when hrs borrows.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             day <= '0;
      else if (digit_load) day <= day_src;
      else if (hrs_bo)     day <= day - DAY_W'(1);
   end

endmodule

// File: tb/tb_dhms_countdown.sv
// Randomized and directed bench for dhms_countdown against a seconds-based model.
module tb_dhms_countdown;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
   logic [4:0] load_day = '0, load_hrs = '0;
   logic [5:0] load_min = '0, load_sec = '0;
   logic [4:0] day, hrs;
   logic [5:0] min, sec;
   logic       running, done, load_err;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;

   dhms_countdown #(.DAY_MAX(30)) dut (
      .clk(clk), .rst(rst), .tick(tick), .load(load),
      .load_day(load_day), .load_hrs(load_hrs),
      .load_min(load_min), .load_sec(load_sec),
      .start(start), .stop(stop),
      .day(day), .hrs(hrs), .min(min), .sec(sec),
      .running(running), .done(done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   // Model: remaining time as a plain count of seconds.
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
   int m_rem = 0, m_shadow = 0, m_st = M_IDLE;
   bit m_done = 0, m_err = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pack(input int r, input bit run,
                                        input bit dn, input bit er);
      logic [4:0] d, h;
      logic [5:0] m, s;
      d = 5'(r / 86400);
      h = 5'((r % 86400) / 3600);
      m = 6'((r % 3600) / 60);
      s = 6'(r % 60);
      return {7'b0, d, h, m, s, run, dn, er};
   endfunction

   function automatic logic [31:0] dut_word();
      return {7'b0, day, hrs, min, sec, running, done, load_err};
   endfunction

   task automatic model_step(input bit ld, input int d, input int h,
                             input int m, input int s,
                             input bit sa, input bit sp, input bit tk);
      m_done = 0;
      m_err  = 0;
      if (ld) begin
         if (s <= 59 && m <= 59 && h <= 23 && d <= 30) begin
            m_rem    = d * 86400 + h * 3600 + m * 60 + s;
            m_shadow = m_rem;
            m_st     = M_IDLE;
         end else begin
            m_err = 1;
         end
      end else if (sp && m_st == M_RUN) begin
         m_st = M_PAUSE;
      end else if (sa && (m_st == M_IDLE || m_st == M_PAUSE)) begin
         if (m_rem != 0) m_st = M_RUN;
         else begin m_st = M_EXP; m_done = 1; end
      end else if (tk && m_st == M_RUN) begin
         m_rem--;
         if (m_rem == 0) begin
            m_done = 1;
`ifdef DHMS_CD_AUTO_RELOAD_EN
            if (m_shadow != 0) m_rem = m_shadow;
            else m_st = M_EXP;
`else
            m_st = M_EXP;
`endif
         end
      end
   endtask

   task automatic cyc(input string tag, input bit ld, input int d,
                      input int h, input int m, input int s,
                      input bit sa, input bit sp, input bit tk);
      load = ld; start = sa; stop = sp; tick = tk;
      load_day = 5'(d); load_hrs = 5'(h);
      load_min = 6'(m); load_sec = 6'(s);
      @(posedge clk);
      model_step(ld, d, h, m, s, sa, sp, tk);
      #1;
      check(tag, dut_word(), pack(m_rem, m_st == M_RUN, m_done, m_err));
      if (done) done_cnt++;
      load = 0; start = 0; stop = 0; tick = 0;
   endtask

   task automatic do_load(input int d, input int h, input int m, input int s);
      cyc("load", 1, d, h, m, s, 0, 0, 0);
   endtask
   task automatic do_start(); cyc("start", 0, 0, 0, 0, 0, 1, 0, 0); endtask
   task automatic do_tick();  cyc("tick", 0, 0, 0, 0, 0, 0, 0, 1); endtask
   task automatic do_idle();  cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0); endtask

   initial begin
      #1;
      check("reset", dut_word(), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      do_idle();

      // 0:0:1:5 runs out after exactly 65 ticks
      do_load(0, 0, 1, 5);
      do_start();
      done_cnt = 0;
      for (int i = 0; i < 65; i++) do_tick();
`ifndef DHMS_CD_AUTO_RELOAD_EN
      check("exp65_cnt", {day, hrs, min, sec}, 22'd0);
      check("exp65_run", running, 1'b0);
      do_start();
      check("exp_start_ign", running, 1'b0);
`endif
      do_idle();
      check("exp65_done", done_cnt, 1);

      // Full borrow chain
      do_load(1, 0, 0, 0);
      do_start();
      do_tick();
      check("borrow", {day, hrs, min, sec}, {5'd0, 5'd23, 6'd59, 6'd59});

      // Rejected loads leave count and state alone
      do_load(0, 0, 0, 60);
      check("err_sec", load_err, 1'b1);
      do_idle();
      check("err_once", load_err, 1'b0);
      do_load(31, 0, 0, 0);
      do_load(0, 24, 0, 0);
      do_load(0, 0, 60, 0);
      check("err_keep", {day, hrs, min, sec}, {5'd0, 5'd23, 6'd59, 6'd59});

      // stop + tick: pause without decrement; resume decrements on next tick
      cyc("stop_tick", 0, 0, 0, 0, 0, 0, 1, 1);
      check("paused", running, 1'b0);
      cyc("pause_tick", 0, 0, 0, 0, 0, 0, 0, 1);
      do_start();
      do_tick();
      check("resume", sec, 6'd58);

      // start + tick in IDLE: run without decrement
      do_load(0, 0, 0, 9);
      cyc("start_tick", 0, 0, 0, 0, 0, 1, 0, 1);
      check("st_tk_sec", sec, 6'd9);
      // load + tick: loaded value wins
      cyc("load_tick", 1, 2, 3, 4, 5, 0, 0, 1);

      // Zero start expires immediately
      do_load(0, 0, 0, 0);
      done_cnt = 0;
      do_start();
      check("zero_done", done, 1'b1);
      do_start();
      do_idle();
      check("zero_once", done_cnt, 1);

`ifdef DHMS_CD_AUTO_RELOAD_EN
      do_load(0, 0, 0, 2);
      do_start();
      done_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         do_tick();
         check("ar_run", running, 1'b1);
      end
      check("ar_done", done_cnt, 2);
      check("ar_sec", sec, 6'd2);
`endif

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         bit ld, sa, sp, tk;
         int d, h, m, s;
         ld = ($urandom_range(0, 39) == 0);
         sa = ($urandom_range(0, 9) == 0);
         sp = ($urandom_range(0, 24) == 0);
         tk = ($urandom_range(0, 1) == 0);
         if ($urandom_range(0, 7) == 0) begin
            d = $urandom_range(0, 31); h = $urandom_range(0, 31);
            m = $urandom_range(0, 63); s = $urandom_range(0, 63);
         end else begin
            d = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
            h = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 1) : 0;
            m = $urandom_range(0, 2);
            s = $urandom_range(0, 59);
         end
         cyc("rand", ld, d, h, m, s, sa, sp, tk);
      end

      // Asynchronous reset mid-count
      do_load(0, 5, 0, 0);
      do_start();
      do_tick();
      #2 rst = 1;
      #1;
      check("rst_async", dut_word(), 32'd0);
      m_rem = 0; m_shadow = 0; m_st = M_IDLE;
      @(posedge clk);
      #1;
      check("rst_hold", dut_word(), 32'd0);
      rst = 0;
      do_idle();
      do_start();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dhms_countdown.md
# dhms_countdown

Days/hours/minutes/seconds countdown timer: loads a d:h:m:s value, decrements it once per 1 Hz tick strobe with borrow propagation, and flags expiry. It is the down-counting counterpart of the team's elapsed-time d/h/m/s counter. It sits behind the same tick generator and drives the same display/readout path.

## Interface
Parameters:
- DAY_MAX, 30, largest loadable day value. Day field is 5 bits wide, so DAY_MAX ≤ 31.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- tick  input  1  single-cycle 1 Hz enable strobe
- load  input  1  load request; sampled every cycle
- load_day  input  5  day value to load, 0..DAY_MAX
- load_hrs  input  5  hour value to load, 0..23
- load_min  input  6  minute value to load, 0..59
- load_sec  input  6  second value to load, 0..59
- start  input  1  start or resume request
- stop  input  1  pause request
- day  output  5  remaining days
- hrs  output  5  remaining hours
- min  output  6  remaining minutes
- sec  output  6  remaining seconds
- running  output  1  high while in RUN
- done  output  1  one-cycle expiry pulse
- load_err  output  1  one-cycle pulse when a load is rejected

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED.
- Reset values: state IDLE; day, hrs, min, sec, running, done and load_err all 0; shadow load registers 0.
- Request priority within a cycle: load, then stop, then start, then tick.
- load, in any state:
  - Valid when every field is in range (sec ≤ 59, min ≤ 59, hrs ≤ 23, day ≤ DAY_MAX).
  - Valid load: copy fields into the count and shadow registers; state becomes IDLE.
  - Invalid load: count and state unchanged; load_err pulses.
- start:
  - In IDLE or PAUSE with a non-zero count: state becomes RUN.
  - In IDLE with a zero count: state becomes EXPIRED and done pulses.
  - In EXPIRED: ignored.
- stop in RUN: state becomes PAUSE. The count holds.
- tick in RUN decrements the count:
  - sec > 0: sec−1.
  - sec = 0: sec becomes 59 and min borrows. Min wraps 0→59 and borrows from hrs. Hrs wraps 0→23 and borrows from day.
  - Day never wraps; the zero check below prevents it.
- Expiry: when the count is 0:0:0:1 and tick arrives in RUN, the count becomes 0:0:0:0, state becomes EXPIRED and done pulses.
- tick in IDLE, PAUSE or EXPIRED: ignored.
- running equals (state == RUN).

## Timing
- All outputs are registered.
- A count update is visible the cycle after the tick edge.
- done and load_err are high for exactly one cycle, the cycle after the triggering edge.
- start and tick in the same cycle in IDLE: the state goes to RUN with no decrement. The first decrement happens on the next tick.
- stop and tick in the same cycle in RUN: the state goes to PAUSE with no decrement.
- load and tick in the same cycle: the loaded value wins.
- rst asserted mid-count: outputs go to their reset values immediately, with no done pulse.

## Configuration
- DHMS_CD_AUTO_RELOAD_EN defined:
  - On expiry, done still pulses.
  - The count reloads from the shadow registers and the state stays RUN (periodic timer).
  - If the shadow value is zero, the block goes to EXPIRED instead.
- DHMS_CD_AUTO_RELOAD_EN undefined:
  - The block goes to EXPIRED and holds 0:0:0:0.
  - The shadow registers are not built.

## Structure
- Shared package dhms_pkg holds:
  - constants SEC_MAX = 59, MIN_MAX = 59, HRS_MAX = 23;
  - the field widths;
  - the state enum dhms_cd_state_t.
- One sub-module, dhms_down_digit: a modulo-(MAX+1) down counter with parameter MAX.
  - Inputs en and load.
  - Outputs value and borrow_out; borrow_out is high when en is asserted and the value is 0.
  - Instantiated for sec, min and hrs. Day uses plain decrement.

## Test plan
- Load 0:0:1:5, start, apply 65 ticks → count 0:0:0:0 after the 65th tick; done pulses once; running falls; state EXPIRED.
- Load 1:0:0:0, start, 1 tick → count 0:23:59:59.
- Load with sec = 60 → load_err pulses one cycle; count and state unchanged. Load with day = 31 → rejected in the same way.
- RUN, stop+tick in the same cycle → no decrement; PAUSE. Then start → RUN; the next tick decrements by 1.
- Load 0:0:0:0, start → done pulses the following cycle; EXPIRED; a later start is ignored.
- With DHMS_CD_AUTO_RELOAD_EN: load 0:0:0:2, start, 4 ticks → done pulses after the 2nd and 4th ticks; count is 0:0:0:2 after each expiry; running stays 1.
